freq_to_div_count: RTL and testbench
====================================

// Module: freq_to_div_count
// PURPOSE
//  Upstream stage of the 32-bit clock divider: converts a requested output frequency in Hz
//  into the half-period count the divider consumes on div_clk_count.
//  Uses an iterative restoring divider: count = CLK_HZ / (2*freq_hz), one quotient bit per clock.
//  Request/ready handshake; the output register holds its last good value between requests.
// PARAMETERS
//  CLK_HZ         50_000_000  inclk frequency in Hz; must be < 2^32
//  DEFAULT_COUNT  25_000      div_clk_count reset value (1 kHz at 50 MHz)
//  DIV_STEPS      33          iterations per divide (dividend width); fixed, do not override
// PORTS
//  inclk          in   1   system clock; all logic on posedge
//  Reset          in   1   asynchronous, active-low reset
//  req_valid      in   1   new frequency request
//  req_freq_hz    in   32  requested output frequency, Hz
//  req_ready      out  1   high only in IDLE; request accepted on req_valid & req_ready
//  div_clk_count  out  32  half-period count to divider (divider toggles every N inclk)
//  count_update   out  1   one-cycle pulse when div_clk_count takes a new value
//  busy           out  1   high from LOAD through DONE
//  req_err        out  1   one-cycle pulse when a request with req_freq_hz==0 is accepted
// BEHAVIOUR
//  Reset (async, Reset==0): state=IDLE; div_clk_count=DEFAULT_COUNT; count_update=0; busy=0;
//   req_err=0; req_ready=1 once Reset deasserts. Reset mid-divide aborts; result discarded.
//  FSM: IDLE -> LOAD -> DIVIDE (DIV_STEPS cycles) -> DONE -> IDLE.
//  IDLE: on accept with freq!=0 latch freq, go to LOAD. With freq==0: pulse req_err next cycle,
//   stay IDLE, div_clk_count unchanged.
//  LOAD (1 clk): dividend(33b) = CLK_HZ (+ rounding term, see CONFIGURATION);
//   divisor(33b) = {freq,1'b0}; remainder=0; quotient=0; step counter=0.
//  DIVIDE: each clk shift {rem,dividend} left 1; if rem>=divisor, subtract and set quotient bit.
//   Step counter 0..DIV_STEPS-1; leave after step DIV_STEPS-1.
//  DONE (1 clk): q = quotient; if q==0 -> 1 (freq > CLK_HZ/2 clamps to fastest toggle);
//   if q>2^32-1 -> 32'hFFFF_FFFF; register to div_clk_count, pulse count_update.
//  Latency: accept at edge T -> div_clk_count/count_update visible after edge T+DIV_STEPS+2 (=T+35).
//  req_valid while busy: req_ready=0, ignored (not queued); requester must hold valid.
//  div_clk_count never changes except in DONE or reset; never 0 after reset.
// CONFIGURATION
//  FREQ_ROUND_NEAREST_EN defined: dividend = CLK_HZ + freq (round half up to nearest count).
//  Not defined: dividend = CLK_HZ (floor). All other timing identical.
// STRUCTURE
//  Package freq_div_pkg: FSM state enum (IDLE, LOAD, DIVIDE, DONE), DIV_W=33, CNT_W=32,
//   CLAMP_MIN=1, CLAMP_MAX=32'hFFFF_FFFF.
//  Sub-module seq_restoring_div: start/done, 33-bit dividend/divisor, 33-bit quotient;
//   top keeps handshake, clamp and output register.
// TESTING  (CLK_HZ=50_000_000)
//  req 1000 -> after 35 clks div_clk_count=25000, count_update 1 clk, busy low next cycle.
//  req 440 -> 56818 (both builds); req 7 -> 3571428 floor / 3571429 with FREQ_ROUND_NEAREST_EN.
//  req 0 -> req_err 1-clk pulse, count_update stays 0, div_clk_count unchanged, req_ready=1.
//  req 30_000_000 -> quotient 0 clamped, div_clk_count=1; req 1 -> 25_000_000.
//  req 1000, new req 2000 at +5 clks -> req_ready=0, ignored; result 25000; then 2000 -> 12500.
//  Reset low at +10 clks of a divide -> div_clk_count=25000 immediately, no count_update, IDLE.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared types and constants for the frequency-to-divider-count converter.
// Optional feature macro: FREQ_ROUND_NEAREST_EN (used by freq_to_div_count).
package freq_div_pkg;

  localparam int DIV_W = 33;
  localparam int CNT_W = 32;

  localparam logic [CNT_W-1:0] CLAMP_MIN = 32'd1;
  localparam logic [CNT_W-1:0] CLAMP_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIVIDE,
    DONE
  } state_t;

  // A zero quotient means the request is faster than the divider can toggle,
  // so it becomes the fastest legal count; anything beyond 32 bits saturates.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [DIV_W-1:0] q);
    logic [CNT_W-1:0] r;
    if (q == '0) begin
      r = CLAMP_MIN;
    end else if (q[DIV_W-1]) begin
      r = CLAMP_MAX;
    end else begin
      r = q[CNT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_to_div_count_if.sv
// Request/result bundle between a frequency requester and freq_to_div_count.
// Optional feature macro: FREQ_ROUND_NEAREST_EN (no effect on this interface).
interface freq_to_div_count_if;

  logic        req_valid;
  logic [31:0] req_freq_hz;
  logic        req_ready;
  logic [31:0] div_clk_count;
  logic        count_update;
  logic        busy;
  logic        req_err;

  modport master (
    output req_valid,
    output req_freq_hz,
    input  req_ready,
    input  div_clk_count,
    input  count_update,
    input  busy,
    input  req_err
  );

  modport slave (
    input  req_valid,
    input  req_freq_hz,
    output req_ready,
    output div_clk_count,
    output count_update,
    output busy,
    output req_err
  );

endinterface

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider: one quotient bit per clock, STEPS iterations.
// 'done' is high during the final iteration; quotient is complete the cycle after.
// Optional feature macro: FREQ_ROUND_NEAREST_EN (no effect on this module).
module seq_restoring_div
  import freq_div_pkg::*;
#(
  parameter int STEPS = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  logic             active_q, active_d;
  logic [5:0]       step_q, step_d;
  logic [DIV_W-1:0] dvd_q, dvd_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W:0]   shifted;
  logic             fits;

  // Load operands on start, then shift-compare-subtract once per clock.
  always_comb begin
    active_d = active_q;
    step_d   = step_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    shifted  = {rem_q, dvd_q[DIV_W-1]};
    fits     = (shifted >= {1'b0, dvs_q});
    done     = active_q && (step_q == LAST_STEP);
    if (start) begin
      active_d = 1'b1;
      step_d   = '0;
      dvd_d    = dividend;
      dvs_d    = divisor;
      rem_d    = '0;
      quo_d    = '0;
    end else if (active_q) begin
      dvd_d = {dvd_q[DIV_W-2:0], 1'b0};
      if (fits) begin
        rem_d = shifted[DIV_W-1:0] - dvs_q;
        quo_d = {quo_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DIV_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b0};
      end
      step_d = step_q + 6'd1;
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  // Divider state registers; reset abandons any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      step_q   <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      active_q <= active_d;
      step_q   <= step_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/freq_to_div_count.sv
// Converts a requested output frequency (Hz) into the half-period count
// CLK_HZ / (2*freq) consumed by the clock divider.
// Optional feature macro: FREQ_ROUND_NEAREST_EN -- when defined the count is
// rounded to nearest (half up) instead of truncated.
module freq_to_div_count
  import freq_div_pkg::*;
#(
  parameter logic [31:0] CLK_HZ        = 32'd50_000_000,
  parameter logic [31:0] DEFAULT_COUNT = 32'd25_000,
  parameter int          DIV_STEPS     = 33
) (
  input logic                inclk,
  input logic                Reset,
  freq_to_div_count_if.slave bus
);

  state_t           state_q, state_d;
  logic [31:0]      freq_q, freq_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_update_q, count_update_d;
  logic             req_err_q, req_err_d;
  logic             div_start;
  logic             div_done;
  logic [DIV_W-1:0] div_dividend;
  logic [DIV_W-1:0] div_divisor;
  logic [DIV_W-1:0] div_quotient;

`ifdef FREQ_ROUND_NEAREST_EN
  assign div_dividend = {1'b0, CLK_HZ} + {1'b0, freq_q};
`else
  assign div_dividend = {1'b0, CLK_HZ};
`endif
  assign div_divisor = {freq_q, 1'b0};

  seq_restoring_div #(
    .STEPS(DIV_STEPS)
  ) u_div (
    .clk     (inclk),
    .rst_n   (Reset),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .done    (div_done),
    .quotient(div_quotient)
  );

  // Handshake, sequencing and result capture for one request at a time.
  always_comb begin
    state_d        = state_q;
    freq_d         = freq_q;
    count_d        = count_q;
    count_update_d = 1'b0;
    req_err_d      = 1'b0;
    div_start      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_freq_hz == 32'd0) begin
            req_err_d = 1'b1;
          end else begin
            freq_d  = bus.req_freq_hz;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        div_start = 1'b1;
        state_d   = DIVIDE;
      end
      DIVIDE: begin
        if (div_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        count_d        = clamp_count(div_quotient);
        count_update_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset restores the default count at once.
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= IDLE;
      freq_q         <= '0;
      count_q        <= DEFAULT_COUNT;
      count_update_q <= 1'b0;
      req_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      freq_q         <= freq_d;
      count_q        <= count_d;
      count_update_q <= count_update_d;
      req_err_q      <= req_err_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.div_clk_count = count_q;
  assign bus.count_update  = count_update_q;
  assign bus.req_err       = req_err_q;

endmodule

// File: tb/tb_freq_to_div_count.sv
// Self-checking bench for freq_to_div_count (CLK_HZ = 50 MHz).
// Honours FREQ_ROUND_NEAREST_EN to pick the expected rounding mode.
module tb_freq_to_div_count;

  localparam longint unsigned CLK_HZ_TB = 64'd50_000_000;
  localparam logic [31:0]     DEF_COUNT = 32'd25_000;
`ifdef FREQ_ROUND_NEAREST_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic inclk;
  logic Reset;
  int   n_checks;
  int   n_fails;
  logic [31:0] f;
  logic [31:0] held_count;
  bit          seen_update;

  freq_to_div_count_if bus ();

  freq_to_div_count #(
    .CLK_HZ       (32'd50_000_000),
    .DEFAULT_COUNT(DEF_COUNT),
    .DIV_STEPS    (33)
  ) dut (
    .inclk(inclk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  // Reference: count = (CLK_HZ [+ freq]) / (2*freq), clamped to [1, 2^32-1].
  function automatic logic [31:0] model_count(input logic [31:0] freq);
    longint unsigned num;
    longint unsigned q;
    num = CLK_HZ_TB + (ROUND ? longint'(freq) : 64'd0);
    q   = num / (64'd2 * longint'(freq));
    if (q == 0) return 32'd1;
    if (q > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic applyStimulus(input logic [31:0] freq);
    int waited;
    waited = 0;
    bus.req_valid   = 1'b1;
    bus.req_freq_hz = freq;
    while (bus.req_ready !== 1'b1 && waited < 200) begin
      @(posedge inclk);
      #1;
      waited++;
    end
    checkOutput("ready_timeout", 32'(waited < 200), 32'd1);
    @(posedge inclk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Called 1ns after the accepting edge T; checks timing and the result at T+35.
  task automatic checkResult(input string tag, input logic [31:0] exp);
    checkOutput({tag, " busy_running"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " ready_running"}, 32'(bus.req_ready), 32'd0);
    repeat (34) @(posedge inclk);
    #1;
    checkOutput({tag, " early_update"}, 32'(bus.count_update), 32'd0);
    @(posedge inclk);
    #1;
    checkOutput({tag, " update"}, 32'(bus.count_update), 32'd1);
    checkOutput({tag, " count"}, bus.div_clk_count, exp);
    checkOutput({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    @(posedge inclk);
    #1;
    checkOutput({tag, " pulse_end"}, 32'(bus.count_update), 32'd0);
    checkOutput({tag, " count_hold"}, bus.div_clk_count, exp);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    bus.req_valid   = 1'b0;
    bus.req_freq_hz = 32'd0;
    Reset           = 1'b1;
    #2 Reset = 1'b0;
    #2;
    checkOutput("reset count", bus.div_clk_count, DEF_COUNT);
    checkOutput("reset update", 32'(bus.count_update), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset err", 32'(bus.req_err), 32'd0);
    @(negedge inclk);
    Reset = 1'b1;
    @(posedge inclk);
    #1;
    checkOutput("ready after reset", 32'(bus.req_ready), 32'd1);

    applyStimulus(32'd1000);
    checkResult("f1000", 32'd25_000);

    applyStimulus(32'd440);
    checkResult("f440", 32'd56_818);

    applyStimulus(32'd7);
    checkResult("f7", ROUND ? 32'd3_571_429 : 32'd3_571_428);

    // Zero request: error pulse only, count untouched.
    held_count = bus.div_clk_count;
    applyStimulus(32'd0);
    checkOutput("zero err", 32'(bus.req_err), 32'd1);
    checkOutput("zero update", 32'(bus.count_update), 32'd0);
    checkOutput("zero ready", 32'(bus.req_ready), 32'd1);
    checkOutput("zero busy", 32'(bus.busy), 32'd0);
    @(posedge inclk);
    #1;
    checkOutput("zero err_end", 32'(bus.req_err), 32'd0);
    checkOutput("zero count", bus.div_clk_count, held_count);

    applyStimulus(32'd30_000_000);
    checkResult("f30M clamp", 32'd1);

    applyStimulus(32'd1);
    checkResult("f1", 32'd25_000_000);

    // Request while busy is refused until the first one finishes.
    applyStimulus(32'd1000);
    repeat (5) @(posedge inclk);
    #1;
    bus.req_valid   = 1'b1;
    bus.req_freq_hz = 32'd2000;
    #1;
    checkOutput("busy ready", 32'(bus.req_ready), 32'd0);
    repeat (29) @(posedge inclk);
    #1;
    checkOutput("busy early_update", 32'(bus.count_update), 32'd0);
    @(posedge inclk);
    #1;
    checkOutput("busy first update", 32'(bus.count_update), 32'd1);
    checkOutput("busy first count", bus.div_clk_count, 32'd25_000);
    applyStimulus(32'd2000);
    checkResult("f2000 held", 32'd12_500);

    // Reset in the middle of a divide.
    applyStimulus(32'd440);
    repeat (9) @(posedge inclk);
    #1;
    Reset = 1'b0;
    #1;
    checkOutput("abort count", bus.div_clk_count, DEF_COUNT);
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort update", 32'(bus.count_update), 32'd0);
    @(negedge inclk);
    Reset = 1'b1;
    seen_update = 1'b0;
    repeat (40) begin
      @(posedge inclk);
      #1;
      if (bus.count_update === 1'b1) seen_update = 1'b1;
    end
    checkOutput("abort no_update", 32'(seen_update), 32'd0);
    checkOutput("abort count_kept", bus.div_clk_count, DEF_COUNT);
    checkOutput("abort ready", 32'(bus.req_ready), 32'd1);

    // Randomized frequencies against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) f = $urandom;
      else f = $urandom_range(200_000, 1);
      if (f == 32'd0) f = 32'd1;
      applyStimulus(f);
      checkResult($sformatf("rand%0d f=%0d", i, f), model_count(f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
